// File: rtl/systolic_feeder_sv.sv
// systolic_feeder_sv: holds one A and one B tile and streams them into a
// SIZE x SIZE systolic MAC array with diagonal skew, sequencing the array
// strobes and pulsing done once the last accumulation has settled.
module systolic_feeder_sv #(
   parameter int SIZE       = 4,
   parameter int DATAWIDTH  = 14,
   parameter int PE_LATENCY = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr_en,
   input  logic                      wr_sel,
   input  logic [$clog2(SIZE)-1:0]   wr_row,
   input  logic [SIZE*DATAWIDTH-1:0] wr_data,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic [SIZE*DATAWIDTH-1:0] a_out,
   output logic [SIZE*DATAWIDTH-1:0] b_out,
   output logic                      load_en,
   output logic                      mult_en,
   output logic                      acc_en
);

   localparam int RW    = $clog2(SIZE);
   localparam int CW    = $clog2(3*SIZE);
   localparam int DW    = DATAWIDTH;
   localparam int STEPS = 3*SIZE - 2;

   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam logic [CW-1:0] LAST_T  = CW'(STEPS - 1);
   localparam logic [CW-1:0] LAST_D  = CW'(PE_LATENCY - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, FIN} state_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_inc;
   logic [SIZE*DW-1:0]    buf_a [SIZE];
   logic [SIZE*DW-1:0]    buf_b [SIZE];
   logic [SIZE*DW-1:0]    a_nx;
   logic [SIZE*DW-1:0]    b_nx;

   // Tile buffers: only writable while idle, never cleared by reset.
   always_ff @(posedge clk) begin
      if (wr_en && state == IDLE) begin
         if (wr_sel) buf_b[wr_row] <= wr_data;
         else        buf_a[wr_row] <= wr_data;
      end
   end

   // Saturating step counter increment so it can never wrap.
   always_comb begin
      cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
   end

   // Skewed operand selection for step cnt: lane k carries element (cnt-k).
   always_comb begin
      a_nx = '0;
      b_nx = '0;
      for (int k = 0; k < SIZE; k++) begin
         int j;
         j = int'(cnt) - k;
         if (j >= 0 && j < SIZE) begin
            a_nx[k*DW +: DW] = buf_a[k][j*DW +: DW];
            b_nx[k*DW +: DW] = buf_b[j[RW-1:0]][k*DW +: DW];
         end
      end
   end

   // Sequencer: all outputs registered, so each state's effect appears one cycle later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         a_out   <= '0;
         b_out   <= '0;
         load_en <= 1'b0;
         mult_en <= 1'b0;
         acc_en  <= 1'b0;
      end else begin
         done    <= 1'b0;
         load_en <= 1'b0;
         mult_en <= 1'b0;
         acc_en  <= 1'b0;
         a_out   <= '0;
         b_out   <= '0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
               end
            end
            CLEAR: begin
               load_en <= 1'b1;
               cnt     <= '0;
               state   <= STREAM;
            end
            STREAM: begin
               mult_en <= 1'b1;
               acc_en  <= 1'b1;
               a_out   <= a_nx;
               b_out   <= b_nx;
               if (cnt == LAST_T) begin
                  cnt   <= '0;
                  state <= DRAIN;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            DRAIN: begin
               mult_en <= 1'b1;
               acc_en  <= 1'b1;
               if (cnt == LAST_D) begin
                  cnt   <= '0;
                  state <= FIN;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_feeder_sv.sv
// Bench for systolic_feeder_sv: a schedule-level model (start time plus tile
// snapshot -> expected outputs per cycle) checked every cycle, plus directed
// literal expectations for skew, strobes, protection and reset.
module tb_systolic_feeder_sv;

   localparam int SIZE = 4;
   localparam int DW   = 14;
   localparam int W    = SIZE*DW;
   localparam int LAT  = 15;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          wr_en = 1'b0;
   logic          wr_sel = 1'b0;
   logic [1:0]    wr_row = '0;
   logic [W-1:0]  wr_data = '0;
   logic          start = 1'b0;
   logic          busy, done, load_en, mult_en, acc_en;
   logic [W-1:0]  a_out, b_out;

   systolic_feeder_sv #(.SIZE(SIZE), .DATAWIDTH(DW), .PE_LATENCY(2)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
      .wr_data(wr_data), .start(start), .busy(busy), .done(done),
      .a_out(a_out), .b_out(b_out), .load_en(load_en), .mult_en(mult_en),
      .acc_en(acc_en)
   );

   always #5 clk = ~clk;

   int passes = 0;
   int checks = 0;
   int done_cnt = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h, required %0h", nm, got, exp);
   endtask

   // ---------------- model ----------------
   logic [DW-1:0] mA [SIZE][SIZE];
   logic [DW-1:0] mB [SIZE][SIZE];
   logic [DW-1:0] sA [SIZE][SIZE];
   logic [DW-1:0] sB [SIZE][SIZE];
   int  ecount = 0;
   int  run_start = 0;
   bit  run_active = 1'b0;

   // Edge-level model: buffers and start only take effect while idle.
   always @(posedge clk) begin
      if (!reset) begin
         ecount++;
         if (!run_active || (ecount - run_start) >= LAT) begin
            if (wr_en)
               for (int j = 0; j < SIZE; j++)
                  if (wr_sel) mB[wr_row][j] = wr_data[j*DW +: DW];
                  else        mA[wr_row][j] = wr_data[j*DW +: DW];
            if (start) begin
               sA = mA;
               sB = mB;
               run_start  = ecount;
               run_active = 1'b1;
            end
         end
      end
   end

   always @(posedge reset) run_active = 1'b0;

   // Per-cycle comparison against the schedule derived from the start time.
   always @(negedge clk) begin
      int rel;
      int t;
      logic [4:0]   ec;
      logic [W-1:0] ea;
      logic [W-1:0] eb;
      rel = run_active ? (ecount - run_start + 1) : -100;
      ec = {(rel >= 1 && rel <= 14), (rel == 15), (rel == 2),
            (rel >= 3 && rel <= 14), (rel >= 3 && rel <= 14)};
      ea = '0;
      eb = '0;
      t = rel - 3;
      if (t >= 0 && t <= 3*SIZE-3)
         for (int k = 0; k < SIZE; k++)
            if (t - k >= 0 && t - k < SIZE) begin
               ea[k*DW +: DW] = sA[k][t-k];
               eb[k*DW +: DW] = sB[t-k][k];
            end
      chk("ctrl", 64'({busy, done, load_en, mult_en, acc_en}), 64'(ec));
      chk("a_out", 64'(a_out), 64'(ea));
      chk("b_out", 64'(b_out), 64'(eb));
      if (done) done_cnt++;
   end

   // ---------------- directed stimulus ----------------
   logic [W-1:0] obs_a [0:17];
   logic [W-1:0] obs_b [0:17];
   logic [4:0]   obs_c [0:17];

   function automatic logic [DW-1:0] el(input logic [W-1:0] v, input int k);
      return v[k*DW +: DW];
   endfunction

   task automatic write_row(input bit sel, input int row, input logic [W-1:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_sel = sel; wr_row = row[1:0]; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic start_capture(input bit with_write, input logic [W-1:0] d);
      @(negedge clk);
      start = 1'b1;
      if (with_write) begin
         wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_data = d;
      end
      for (int r = 1; r <= 17; r++) begin
         @(negedge clk);
         start = 1'b0;
         wr_en = 1'b0;
         obs_a[r] = a_out;
         obs_b[r] = b_out;
         obs_c[r] = {busy, done, load_en, mult_en, acc_en};
      end
   endtask

   // A = 10*i+j, B = identity; stream cycle t is visible 3 cycles after the start edge's cycle 0.
   task automatic check_skew();
      for (int t = 0; t < 4; t++) chk("a0_skew", 64'(el(obs_a[t+3], 0)), 64'(t));
      for (int t = 0; t < 10; t++)
         chk("a3_skew", 64'(el(obs_a[t+3], 3)), (t >= 3 && t <= 6) ? 64'(30 + t - 3) : 64'd0);
      for (int k = 0; k < SIZE; k++)
         for (int t = 0; t < 10; t++)
            chk("b_diag", 64'(el(obs_b[t+3], k)), (t == 2*k) ? 64'd1 : 64'd0);
   endtask

   task automatic check_timing();
      int nl, nm, nb;
      nl = 0; nm = 0; nb = 0;
      for (int r = 1; r <= 17; r++) begin
         nl += int'(obs_c[r][2]);
         nm += int'(obs_c[r][1]);
         nb += int'(obs_c[r][4]);
         chk("load_at_2", 64'(obs_c[r][2]), 64'(r == 2));
         chk("done_at_15", 64'(obs_c[r][3]), 64'(r == 15));
         chk("acc_window", 64'(obs_c[r][0]), 64'(r >= 3 && r <= 14));
      end
      chk("load_cycles", 64'(nl), 64'd1);
      chk("mult_cycles", 64'(nm), 64'd12);
      chk("busy_cycles", 64'(nb), 64'd14);
   endtask

   initial begin
      logic [W-1:0] d;
      int d0;
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      chk("reset_state", 64'({busy, done, load_en, mult_en, acc_en}), 64'd0);

      // Load tiles
      for (int i = 0; i < SIZE; i++) begin
         for (int j = 0; j < SIZE; j++) d[j*DW +: DW] = DW'(10*i + j);
         write_row(1'b0, i, d);
         d = '0;
         d[i*DW +: DW] = DW'(1);
         write_row(1'b1, i, d);
      end

      // Skew + strobe timing
      start_capture(1'b0, '0);
      check_skew();
      check_timing();

      // Busy protection: write + start during stream cycle 2
      d0 = done_cnt;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      for (int j = 0; j < SIZE; j++) d[j*DW +: DW] = 14'h3FFF;
      wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_data = d; start = 1'b1;
      @(negedge clk); wr_en = 1'b0; start = 1'b0;
      repeat (30) @(negedge clk);
      chk("single_done", 64'(done_cnt - d0), 64'd1);
      start_capture(1'b0, '0);
      for (int t = 0; t < 4; t++) chk("orig_row", 64'(el(obs_a[t+3], 0)), 64'(t));

      // Same-cycle write plus start
      for (int j = 0; j < SIZE; j++) d[j*DW +: DW] = DW'(j + 1);
      start_capture(1'b1, d);
      for (int t = 0; t < 4; t++) chk("write_start", 64'(el(obs_a[t+3], 0)), 64'(t + 1));

      // Restore A row 0, then abort a run at stream cycle 5
      for (int j = 0; j < SIZE; j++) d[j*DW +: DW] = DW'(j);
      write_row(1'b0, 0, d);
      d0 = done_cnt;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (7) @(negedge clk);
      d = '0;
      d[2*DW +: DW] = DW'(23);
      d[3*DW +: DW] = DW'(32);
      chk("pre_reset_a", 64'(a_out), 64'(d));
      #2 reset = 1'b1;
      #1 chk("async_reset", 64'({busy, done, load_en, mult_en, acc_en, a_out}), 64'd0);
      chk("async_reset_b", 64'(b_out), 64'd0);
      @(negedge clk);
      #2 reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("no_done_abort", 64'(done_cnt - d0), 64'd0);
      start_capture(1'b0, '0);
      check_skew();
      check_timing();

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/systolic_feeder_sv.md
Name: systolic_feeder_sv

Overview:
- Upstream stage of the SIZE x SIZE systolic MAC array.
- Holds one A tile and one B tile in local buffers, written one row per cycle.
- On start, streams the tiles into the array with diagonal skew: row k of A and column k of B are delayed k cycles.
- Sequences the array control strobes (load_en, mult_en, acc_en) and reports completion once the array outputs are final.

Parameters:
- SIZE, 4, array dimension; tiles are SIZE x SIZE.
- DATAWIDTH, 14, element width; matches the array data bus.
- PE_LATENCY, 2, cycles from the last operand entering PE(SIZE-1,SIZE-1) until its acc_out is valid.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  tile buffer write strobe.
- wr_sel  in  1  target buffer: 0 = A, 1 = B.
- wr_row  in  $clog2(SIZE)  row index written.
- wr_data  in  SIZE*DATAWIDTH  packed row; element j is bits [j*DATAWIDTH +: DATAWIDTH].
- start  in  1  begin a tile computation.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the array results are valid.
- a_out  out  SIZE*DATAWIDTH  packed per-row operands; drives array a_in.
- b_out  out  SIZE*DATAWIDTH  packed per-column operands; drives array b_in.
- load_en  out  1  array accumulator clear/load strobe.
- mult_en  out  1  array multiply enable.
- acc_en  out  1  array accumulate enable.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE; step counter goes to 0.
  - All outputs go to 0: busy, done, a_out, b_out, load_en, mult_en, acc_en.
  - Buffer contents are not cleared.
- Writes:
  - When wr_en=1 in IDLE, bufA[wr_row] or bufB[wr_row] (per wr_sel) takes wr_data at the clock edge.
  - wr_en outside IDLE is ignored and the buffers are unchanged.
  - A write and an accepted start in the same IDLE cycle: the write lands first, and streaming uses the updated data.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, FIN.
  - IDLE: on start=1, go to CLEAR and set busy=1 from the next cycle. start in any other state is ignored.
  - CLEAR (1 cycle): load_en=1, a_out=b_out=0, then go to STREAM with t=0.
  - STREAM (3*SIZE-2 cycles, t=0..3*SIZE-3):
    - mult_en=acc_en=1.
    - a_out[k] = A[k][t-k] when 0<=t-k<SIZE, else 0.
    - b_out[k] = B[t-k][k] when 0<=t-k<SIZE, else 0.
    - Outputs are registered: the value for step t appears on the cycle after the state and counter read t. The whole output schedule is therefore offset one cycle after the state sequence.
  - DRAIN (PE_LATENCY cycles): mult_en=acc_en=1, a_out=b_out=0.
  - FIN (1 cycle): done=1, busy=0 in the same cycle, strobes 0, then return to IDLE.
- Timing: from the start edge to the done pulse is 1 + 1 + (3*SIZE-2) + PE_LATENCY + 1 cycles, which is 15 for the defaults.
- Counter is $clog2(3*SIZE) bits wide and saturates; it never wraps within STREAM.
- Reset asserted mid-operation aborts immediately to IDLE, with all outputs 0 and no done pulse.
- Operands are passed through unmodified; there is no arithmetic or truncation.

Test Plan:
- Reset with a_out preloaded by an earlier run:
  - Stimulus: assert reset asynchronously between clock edges.
  - Required: all outputs 0 immediately and state IDLE.
- Skew check (SIZE=4):
  - Stimulus: load A[i][j] = 10*i+j and B = identity, then start.
  - Required: a_out[0] shows 0,1,2,3 on stream cycles 0-3; a_out[3] shows 30,31,32,33 on cycles 3-6 and 0 otherwise.
  - Required: b_out[k] is 1 only at stream cycle 2k.
- Strobes and timing (SIZE=4):
  - Stimulus: start.
  - Required: load_en is high exactly one cycle, 2 cycles after the start edge.
  - Required: mult_en/acc_en are high for 12 consecutive cycles.
  - Required: done pulses 15 cycles after start, and busy is high for 14 cycles.
- Busy protection:
  - Stimulus: during STREAM, write bufA row 0 with 0x3FFF and pulse start.
  - Required: the stream is unaffected, the next run uses the original row, and only one done pulse occurs.
- Same-cycle write plus start:
  - Stimulus: in IDLE, write A row 0 = {4,3,2,1} together with start.
  - Required: a_out[0] streams 1,2,3,4.
- Mid-run reset:
  - Stimulus: assert reset at stream cycle 5, then restart.
  - Required: no done pulse for the aborted run; the restarted run matches the skew check exactly.
